// File: rtl/data_array_stream_if.sv
// Bundle between the cache controller/eviction/refill side and the data array.
// The controller side uses the master modport; the array uses slave.
interface data_array_stream_if #(
  parameter int unsigned CACHE_WAY   = 4,
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned OFF_BITS = $clog2(BLOCK_WORDS);

  // Hit access
  logic                  i_rd;
  logic                  i_wr;
  logic [INDEX_BITS-1:0] i_index;
  logic [OFF_BITS-1:0]   i_offset;
  logic [3:0]            i_dm_write;
  logic [31:0]           i_data_from_core;
  logic [CACHE_WAY-1:0]  i_way;
  logic [CACHE_WAY-1:0]  i_lru;
  logic [31:0]           o_data_to_core;
  logic                  o_rd_valid;
  // Eviction stream
  logic                  i_evict_start;
  logic [31:0]           o_evict_data;
  logic                  o_evict_valid;
  logic                  i_evict_ready;
  // Refill stream
  logic                  i_refill_start;
  logic [31:0]           i_refill_data;
  logic                  i_refill_valid;
  logic                  o_refill_ready;
  // Status
  logic                  o_busy;
  logic                  o_done;

  modport master (
    output i_rd, i_wr, i_index, i_offset, i_dm_write, i_data_from_core, i_way, i_lru,
    output i_evict_start, i_evict_ready, i_refill_start, i_refill_data, i_refill_valid,
    input  o_data_to_core, o_rd_valid, o_evict_data, o_evict_valid, o_refill_ready,
    input  o_busy, o_done
  );

  modport slave (
    input  i_rd, i_wr, i_index, i_offset, i_dm_write, i_data_from_core, i_way, i_lru,
    input  i_evict_start, i_evict_ready, i_refill_start, i_refill_data, i_refill_valid,
    output o_data_to_core, o_rd_valid, o_evict_data, o_evict_valid, o_refill_ready,
    output o_busy, o_done
  );
endinterface

// File: rtl/data_array_stream.sv
// Set-associative cache data store: registered hit reads, byte-masked hit writes,
// victim block streaming out and refill block streaming in, one word per beat.
module data_array_stream #(
  parameter int unsigned CACHE_WAY   = 4,
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic                clk,
  input logic                nrst,
  data_array_stream_if.slave bus
);
  localparam int unsigned OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int unsigned WAY_BITS = (CACHE_WAY > 1) ? $clog2(CACHE_WAY) : 1;
  localparam int unsigned ADDR_W   = WAY_BITS + INDEX_BITS + OFF_BITS;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [OFF_BITS-1:0] LastWord = OFF_BITS'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StEvict, StRefill} state_e;

  state_e                state_q, state_d;
  logic [OFF_BITS-1:0]   cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [INDEX_BITS-1:0] vidx_q, vidx_d;
  logic [WAY_BITS-1:0]   vway_q, vway_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q;
  logic [31:0]           rd_data_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  rd_fire, wr_fire, fill_fire;
  logic [WAY_BITS-1:0]   hit_way, lru_way;
  logic                  hit_ok, lru_ok;
  logic [ADDR_W-1:0]     hit_addr, victim_addr;

  // Multi-hot selects resolve to the lowest set bit.
  function automatic logic [WAY_BITS-1:0] first_set(input logic [CACHE_WAY-1:0] v);
    first_set = '0;
    for (int i = int'(CACHE_WAY) - 1; i >= 0; i--) begin
      if (v[i]) first_set = WAY_BITS'(i);
    end
  endfunction

  // Way decode and array addressing
  always_comb begin
    hit_way     = first_set(bus.i_way);
    lru_way     = first_set(bus.i_lru);
    hit_ok      = |bus.i_way;
    lru_ok      = |bus.i_lru;
    hit_addr    = {hit_way, bus.i_index, bus.i_offset};
    victim_addr = {vway_q, vidx_q, cnt_q};
  end

  // Next-state logic; a start in IDLE wins over a same-cycle hit access
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    vidx_d    = vidx_q;
    vway_d    = vway_q;
    done_d    = 1'b0;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    fill_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((bus.i_evict_start || bus.i_refill_start) && lru_ok) begin
          vidx_d = bus.i_index;
          vway_d = lru_way;
          cnt_d  = '0;
          if (bus.i_evict_start) begin
            state_d   = StEvict;
            pending_d = bus.i_refill_start;
          end else begin
            state_d   = StRefill;
            pending_d = 1'b0;
          end
        end else begin
          rd_fire = bus.i_rd && hit_ok;
          wr_fire = bus.i_wr && hit_ok;
        end
      end
      StEvict: begin
        if (bus.i_evict_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            if (pending_q) begin
              state_d   = StRefill;
              pending_d = 1'b0;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      StRefill: begin
        if (bus.i_refill_valid) begin
          fill_fire = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      vidx_q    <= '0;
      vway_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      vidx_q    <= vidx_d;
      vway_q    <= vway_d;
      done_q    <= done_d;
    end
  end

  // Registered hit read; sees pre-write data on a same-cycle write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= mem_q[hit_addr];
    end
  end

  // Storage has no reset; hit writes are byte-masked, refill beats write whole words
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_dm_write[b]) mem_q[hit_addr][8*b +: 8] <= bus.i_data_from_core[8*b +: 8];
      end
    end
    if (fill_fire) mem_q[victim_addr] <= bus.i_refill_data;
  end

  // Output drive
  always_comb begin
    bus.o_data_to_core = rd_data_q;
    bus.o_rd_valid     = rd_valid_q;
    bus.o_evict_valid  = (state_q == StEvict);
    bus.o_evict_data   = (state_q == StEvict) ? mem_q[victim_addr] : '0;
    bus.o_refill_ready = (state_q == StRefill);
    bus.o_busy         = (state_q != StIdle);
    bus.o_done         = done_q;
  end
endmodule

// File: tb/tb_data_array_stream.sv
// Bench for data_array_stream: default 4-way/4-word build plus a 2-way/8-word build.
module tb_data_array_stream;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  data_array_stream_if #(.CACHE_WAY(4), .INDEX_BITS(3), .BLOCK_WORDS(4)) a_if ();
  data_array_stream #(.CACHE_WAY(4), .INDEX_BITS(3), .BLOCK_WORDS(4)) dut_a (
    .clk (clk),
    .nrst(nrst),
    .bus (a_if.slave)
  );

  data_array_stream_if #(.CACHE_WAY(2), .INDEX_BITS(3), .BLOCK_WORDS(8)) b_if ();
  data_array_stream #(.CACHE_WAY(2), .INDEX_BITS(3), .BLOCK_WORDS(8)) dut_b (
    .clk (clk),
    .nrst(nrst),
    .bus (b_if.slave)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.i_rd = 0; a_if.i_wr = 0; a_if.i_index = '0; a_if.i_offset = '0;
    a_if.i_dm_write = '0; a_if.i_data_from_core = '0; a_if.i_way = '0; a_if.i_lru = '0;
    a_if.i_evict_start = 0; a_if.i_evict_ready = 0; a_if.i_refill_start = 0;
    a_if.i_refill_data = '0; a_if.i_refill_valid = 0;
    b_if.i_rd = 0; b_if.i_wr = 0; b_if.i_index = '0; b_if.i_offset = '0;
    b_if.i_dm_write = '0; b_if.i_data_from_core = '0; b_if.i_way = '0; b_if.i_lru = '0;
    b_if.i_evict_start = 0; b_if.i_evict_ready = 0; b_if.i_refill_start = 0;
    b_if.i_refill_data = '0; b_if.i_refill_valid = 0;
  endtask

  task automatic write_a(input logic [2:0] idx, input logic [1:0] off, input logic [3:0] way,
                         input logic [3:0] be, input logic [31:0] d);
    a_if.i_wr = 1; a_if.i_index = idx; a_if.i_offset = off; a_if.i_way = way;
    a_if.i_dm_write = be; a_if.i_data_from_core = d;
    tick();
    a_if.i_wr = 0;
  endtask

  task automatic read_a(input logic [2:0] idx, input logic [1:0] off, input logic [3:0] way);
    a_if.i_rd = 1; a_if.i_index = idx; a_if.i_offset = off; a_if.i_way = way;
    tick();
    a_if.i_rd = 0;
  endtask

  task automatic test_reset();
    nrst = 0;
    idle_all();
    tick(); tick();
    n_cmp++;
    if ({a_if.o_rd_valid, a_if.o_data_to_core, a_if.o_evict_valid, a_if.o_evict_data,
         a_if.o_refill_ready, a_if.o_busy, a_if.o_done} !== '0) begin
      n_err++;
      $display("FAIL reset_a: busy=%b evict_valid=%b refill_ready=%b rd_valid=%b data=%h want all 0",
               a_if.o_busy, a_if.o_evict_valid, a_if.o_refill_ready, a_if.o_rd_valid,
               a_if.o_data_to_core);
    end
    n_cmp++;
    if ({b_if.o_rd_valid, b_if.o_data_to_core, b_if.o_evict_valid, b_if.o_evict_data,
         b_if.o_refill_ready, b_if.o_busy, b_if.o_done} !== '0) begin
      n_err++;
      $display("FAIL reset_b: busy=%b evict_valid=%b refill_ready=%b want all 0",
               b_if.o_busy, b_if.o_evict_valid, b_if.o_refill_ready);
    end
    nrst = 1;
    tick();
  endtask

  task automatic test_hit_rw();
    write_a(3'd5, 2'd2, 4'b0010, 4'hF, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    read_a(3'd5, 2'd2, 4'b0010);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL hit_read: valid=%b data=%h want valid=1 data=%h",
               a_if.o_rd_valid, a_if.o_data_to_core, exp_v);
    end
    tick();
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_valid_pulse: valid=%b want 0", a_if.o_rd_valid);
    end
    // No way selected: no valid, data held
    read_a(3'd5, 2'd2, 4'b0000);
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b0 || a_if.o_data_to_core !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL no_way_read: valid=%b data=%h want valid=0 data=deadbeef",
               a_if.o_rd_valid, a_if.o_data_to_core);
    end
    // Multi-hot 0110 resolves to way 1
    write_a(3'd5, 2'd3, 4'b0110, 4'hF, 32'h11112222);
    exp_q.push_back(32'h11112222);
    read_a(3'd5, 2'd3, 4'b0010);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL multi_hot_way: valid=%b data=%h want %h",
               a_if.o_rd_valid, a_if.o_data_to_core, exp_v);
    end
  endtask

  task automatic test_byte_write();
    write_a(3'd5, 2'd2, 4'b0010, 4'b0100, 32'h00AA0000);
    exp_q.push_back(32'hDEAABEEF);
    read_a(3'd5, 2'd2, 4'b0010);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL byte_mask: data=%h want %h", a_if.o_data_to_core, exp_v);
    end
    // Same-cycle read and write of one word returns the old value
    a_if.i_rd = 1; a_if.i_wr = 1; a_if.i_index = 3'd5; a_if.i_offset = 2'd2;
    a_if.i_way = 4'b0010; a_if.i_dm_write = 4'hF; a_if.i_data_from_core = 32'h12345678;
    exp_q.push_back(32'hDEAABEEF);
    tick();
    a_if.i_rd = 0; a_if.i_wr = 0;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL rd_wr_same: data=%h want %h", a_if.o_data_to_core, exp_v);
    end
    exp_q.push_back(32'h12345678);
    read_a(3'd5, 2'd2, 4'b0010);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (a_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL rd_after_wr: data=%h want %h", a_if.o_data_to_core, exp_v);
    end
  endtask

  task automatic test_evict_stall();
    int done_cnt;
    logic r;
    for (int i = 0; i < 4; i++) write_a(3'd3, 2'(i), 4'b1000, 4'hF, 32'h10 + 32'(i));
    // Start with a same-cycle read: the read must be dropped
    a_if.i_evict_start = 1; a_if.i_lru = 4'b1000; a_if.i_index = 3'd3;
    a_if.i_rd = 1; a_if.i_way = 4'b1000; a_if.i_offset = 2'd0;
    tick();
    a_if.i_evict_start = 0; a_if.i_rd = 0;
    n_cmp++;
    if (a_if.o_busy !== 1'b1 || a_if.o_rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL start_priority: busy=%b rd_valid=%b want busy=1 rd_valid=0",
               a_if.o_busy, a_if.o_rd_valid);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + 32'(i));
    done_cnt = 0;
    r = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (a_if.o_done) done_cnt++;
      if (a_if.o_evict_valid) begin
        a_if.i_evict_ready = r;
        n_cmp++;
        if (exp_q.size() == 0 || a_if.o_evict_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL evict_beat: data=%h want %h (queue %0d)", a_if.o_evict_data,
                   (exp_q.size() != 0) ? exp_q[0] : 32'h0, exp_q.size());
        end
        if (r && exp_q.size() != 0) void'(exp_q.pop_front());
        r = ~r;
      end else begin
        a_if.i_evict_ready = 0;
      end
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      n_err++;
      $display("FAIL evict_end: beats_left=%0d done_pulses=%0d want 0 and 1",
               exp_q.size(), done_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_evict_refill();
    int done_cnt, fills;
    bit gapped;
    for (int i = 0; i < 4; i++) write_a(3'd7, 2'(i), 4'b0001, 4'hF, 32'h70 + 32'(i));
    a_if.i_evict_start = 1; a_if.i_refill_start = 1; a_if.i_lru = 4'b0001; a_if.i_index = 3'd7;
    tick();
    a_if.i_evict_start = 0; a_if.i_refill_start = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h70 + 32'(i));
    done_cnt = 0; fills = 0; gapped = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (a_if.o_done) done_cnt++;
      if (a_if.o_evict_valid || a_if.o_refill_ready) begin
        n_cmp++;
        if (a_if.o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_during_seq: busy=%b want 1", a_if.o_busy);
        end
      end
      a_if.i_evict_ready = a_if.o_evict_valid;
      if (a_if.o_evict_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || a_if.o_evict_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL combo_evict: data=%h queue=%0d", a_if.o_evict_data, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      a_if.i_refill_valid = 0;
      if (a_if.o_refill_ready && fills < 4) begin
        if (fills == 2 && !gapped) begin
          gapped = 1;
        end else begin
          a_if.i_refill_valid = 1;
          a_if.i_refill_data = 32'hA0 + 32'(fills);
          fills++;
        end
      end
      tick();
    end
    a_if.i_refill_valid = 0; a_if.i_evict_ready = 0;
    n_cmp++;
    if (exp_q.size() != 0 || fills != 4 || done_cnt != 1 || a_if.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL combo_end: beats_left=%0d fills=%0d done=%0d busy=%b want 0/4/1/0",
               exp_q.size(), fills, done_cnt, a_if.o_busy);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hA0 + 32'(i));
      read_a(3'd7, 2'(i), 4'b0001);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
        n_err++;
        $display("FAIL refill_readback%0d: data=%h want %h", i, a_if.o_data_to_core, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    a_if.i_refill_start = 1; a_if.i_lru = 4'b0100; a_if.i_index = 3'd2;
    tick();
    a_if.i_refill_start = 0;
    for (int i = 0; i < 2; i++) begin
      a_if.i_refill_valid = 1; a_if.i_refill_data = 32'hB0 + 32'(i);
      tick();
    end
    a_if.i_refill_valid = 0;
    #2 nrst = 0;
    #1;
    n_cmp++;
    if ({a_if.o_rd_valid, a_if.o_data_to_core, a_if.o_evict_valid, a_if.o_evict_data,
         a_if.o_refill_ready, a_if.o_busy, a_if.o_done} !== '0) begin
      n_err++;
      $display("FAIL abort_reset: busy=%b refill_ready=%b done=%b want all 0",
               a_if.o_busy, a_if.o_refill_ready, a_if.o_done);
    end
    tick();
    nrst = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'hB0 + 32'(i));
      read_a(3'd2, 2'(i), 4'b0100);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (a_if.o_rd_valid !== 1'b1 || a_if.o_data_to_core !== exp_v) begin
        n_err++;
        $display("FAIL abort_kept%0d: valid=%b data=%h want %h", i, a_if.o_rd_valid,
                 a_if.o_data_to_core, exp_v);
      end
    end
    // Reads while busy are ignored
    a_if.i_evict_start = 1; a_if.i_lru = 4'b0001; a_if.i_index = 3'd7;
    tick();
    a_if.i_evict_start = 0;
    a_if.i_evict_ready = 0; a_if.i_rd = 1; a_if.i_way = 4'b0001; a_if.i_offset = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (a_if.o_rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rd_while_busy: rd_valid=%b want 0", a_if.o_rd_valid);
      end
    end
    a_if.i_rd = 0; a_if.i_evict_ready = 1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (a_if.o_done) done_cnt++;
    end
    a_if.i_evict_ready = 0;
    n_cmp++;
    if (done_cnt != 1 || a_if.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_evict_end: done=%0d busy=%b want 1/0", done_cnt, a_if.o_busy);
    end
  endtask

  task automatic test_wide_build();
    int fills, done_cnt;
    b_if.i_refill_start = 1; b_if.i_lru = 2'b10; b_if.i_index = 3'd4;
    tick();
    b_if.i_refill_start = 0;
    fills = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (b_if.o_done) done_cnt++;
      b_if.i_refill_valid = 0;
      if (b_if.o_refill_ready && fills < 8) begin
        b_if.i_refill_valid = 1;
        b_if.i_refill_data = 32'hC0 + 32'(fills);
        fills++;
      end
      tick();
    end
    b_if.i_refill_valid = 0;
    n_cmp++;
    if (fills != 8 || done_cnt != 1 || b_if.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL wide_refill: fills=%0d done=%0d busy=%b want 8/1/0",
               fills, done_cnt, b_if.o_busy);
    end
    b_if.i_evict_start = 1; b_if.i_lru = 2'b10; b_if.i_index = 3'd4;
    tick();
    b_if.i_evict_start = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0 + 32'(i));
    for (int cyc = 0; cyc < 20; cyc++) begin
      b_if.i_evict_ready = b_if.o_evict_valid;
      if (b_if.o_evict_valid) begin
        n_cmp++;
        if (exp_q.size() == 0 || b_if.o_evict_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL wide_evict: data=%h queue=%0d", b_if.o_evict_data, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
    b_if.i_evict_ready = 0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wide_evict_count: beats_left=%0d want 0", exp_q.size());
    end
    exp_q.delete();
    exp_q.push_back(32'hC5);
    b_if.i_rd = 1; b_if.i_index = 3'd4; b_if.i_offset = 3'd5; b_if.i_way = 2'b10;
    tick();
    b_if.i_rd = 0;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (b_if.o_rd_valid !== 1'b1 || b_if.o_data_to_core !== exp_v) begin
      n_err++;
      $display("FAIL wide_read: data=%h want %h", b_if.o_data_to_core, exp_v);
    end
    // Start with no victim way is ignored
    b_if.i_evict_start = 1; b_if.i_refill_start = 1; b_if.i_lru = 2'b00;
    tick();
    b_if.i_evict_start = 0; b_if.i_refill_start = 0;
    tick();
    n_cmp++;
    if (b_if.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL lru_zero_start: busy=%b want 0", b_if.o_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_all();
    test_reset();
    test_hit_rw();
    test_byte_write();
    test_evict_stall();
    test_evict_refill();
    test_reset_abort();
    test_wide_build();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
